// File: rtl/bayer_tx_pkg.sv
// Shared ISP defines: pixel and color-tag widths, color codes and Bayer phase codes
// used by the raw source, demosaic and later pipeline stages.
package bayer_tx_pkg;

  localparam int ISP_COLOR_DEPTH   = 8;
  localparam int ISP_COLOR_BIT_CNT = 2;

  typedef enum logic [1:0] {
    COLOR_R = 2'd0,
    COLOR_G = 2'd1,
    COLOR_B = 2'd2
  } color_e;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'd0,
    PAT_GRBG = 2'd1,
    PAT_GBRG = 2'd2,
    PAT_BGGR = 2'd3
  } pattern_e;

endpackage

// File: rtl/bayer_tx_color_map.sv
// Combinational Bayer color lookup from phase and pixel parity; shared with demosaic.
module bayer_color_map
  import bayer_tx_pkg::*;
#(
  parameter int COLOR_BIT_CNT = ISP_COLOR_BIT_CNT
) (
  input  logic [1:0]               i_pattern,
  input  logic                     i_row_par,
  input  logic                     i_col_par,
  output logic [COLOR_BIT_CNT-1:0] o_color
);

  logic w_row_eff;
  logic w_col_eff;

  // Every phase is RGGB with the row and/or column parity flipped.
  assign w_row_eff = i_row_par ^ ((i_pattern == PAT_GBRG) || (i_pattern == PAT_BGGR));
  assign w_col_eff = i_col_par ^ ((i_pattern == PAT_GRBG) || (i_pattern == PAT_BGGR));

  always_comb begin
    if (w_row_eff != w_col_eff) begin
      o_color = COLOR_BIT_CNT'(COLOR_G);
    end else if (w_row_eff) begin
      o_color = COLOR_BIT_CNT'(COLOR_B);
    end else begin
      o_color = COLOR_BIT_CNT'(COLOR_R);
    end
  end

endmodule

// File: rtl/bayer_tx.sv
// Raster-order Bayer frame source: reads a frame buffer and streams tagged raw pixels
// with a fixed two-cycle read-to-output latency and optional inter-row gaps.
module bayer_tx
  import bayer_tx_pkg::*;
#(
  parameter int COLOR_DEPTH   = ISP_COLOR_DEPTH,
  parameter int COLOR_BIT_CNT = ISP_COLOR_BIT_CNT,
  parameter int ADDR_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               size_w_log2,
  input  logic [3:0]               size_h_log2,
  input  logic [1:0]               pattern,
  input  logic [3:0]               line_gap,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [COLOR_DEPTH-1:0]   rd_data,
  output logic [COLOR_DEPTH-1:0]   pixel_out,
  output logic                     valid_out,
  output logic [COLOR_BIT_CNT-1:0] color_out,
  output logic                     last_col_out,
  output logic                     last_pic_out,
  output logic                     busy,
  output logic                     finish_operation,
  output logic                     cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_DRAIN} state_e;

  state_e                   r_state;
  logic [3:0]               r_w_log2, r_h_log2, r_gap, r_wait;
  logic [1:0]               r_pattern;
  logic [7:0]               r_row, r_col;
  logic                     r_s1_valid, r_s1_last_col, r_s1_last_pic;
  logic [COLOR_BIT_CNT-1:0] r_s1_color, r_color;
  logic [COLOR_DEPTH-1:0]   r_pixel;
  logic                     r_valid, r_last_col, r_last_pic, r_finish, r_cfg_err;

  logic [8:0]               w_col_max, w_row_max;
  logic                     w_last_col, w_last_row, w_cfg_ok, w_rd;
  logic [COLOR_BIT_CNT-1:0] w_color;
  logic [ADDR_W-1:0]        w_addr;

  assign w_col_max  = (9'd1 << r_w_log2) - 9'd1;
  assign w_row_max  = (9'd1 << r_h_log2) - 9'd1;
  assign w_last_col = ({1'b0, r_col} == w_col_max);
  assign w_last_row = ({1'b0, r_row} == w_row_max);
  assign w_cfg_ok   = (size_w_log2 != 4'd0) && (size_w_log2 <= 4'd8) &&
                      (size_h_log2 != 4'd0) && (size_h_log2 <= 4'd8);
  assign w_rd       = (r_state == S_STREAM);
  assign w_addr     = (ADDR_W'(r_row) << r_w_log2) | ADDR_W'(r_col);

  bayer_color_map #(
    .COLOR_BIT_CNT(COLOR_BIT_CNT)
  ) u_color_map (
    .i_pattern(r_pattern),
    .i_row_par(r_row[0]),
    .i_col_par(r_col[0]),
    .o_color  (w_color)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_w_log2      <= '0;
      r_h_log2      <= '0;
      r_gap         <= '0;
      r_wait        <= '0;
      r_pattern     <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_color    <= '0;
      r_s1_last_col <= 1'b0;
      r_s1_last_pic <= 1'b0;
      r_valid       <= 1'b0;
      r_pixel       <= '0;
      r_color       <= '0;
      r_last_col    <= 1'b0;
      r_last_pic    <= 1'b0;
      r_finish      <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;

      // Stage 1 tracks the read issued this cycle; stage 2 joins it with rd_data.
      r_s1_valid    <= w_rd;
      r_s1_color    <= w_rd ? w_color : '0;
      r_s1_last_col <= w_rd & w_last_col;
      r_s1_last_pic <= w_rd & w_last_col & w_last_row;
      r_valid       <= r_s1_valid;
      r_pixel       <= r_s1_valid ? rd_data : '0;
      r_color       <= r_s1_color;
      r_last_col    <= r_s1_last_col;
      r_last_pic    <= r_s1_last_pic;
      r_finish      <= r_last_pic;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_w_log2  <= size_w_log2;
              r_h_log2  <= size_h_log2;
              r_pattern <= pattern;
              r_gap     <= line_gap;
              r_row     <= '0;
              r_col     <= '0;
              r_state   <= S_STREAM;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (w_last_col) begin
            if (w_last_row) begin
              r_state <= S_DRAIN;
              r_wait  <= 4'd1;
            end else begin
              r_col <= '0;
              r_row <= r_row + 8'd1;
              if (r_gap != 4'd0) begin
                r_state <= S_GAP;
                r_wait  <= r_gap - 4'd1;
              end
            end
          end else begin
            r_col <= r_col + 8'd1;
          end
        end
        S_GAP: begin
          if (r_wait == 4'd0) r_state <= S_STREAM;
          else                r_wait  <= r_wait - 4'd1;
        end
        S_DRAIN: begin
          if (r_wait == 4'd0) r_state <= S_IDLE;
          else                r_wait  <= r_wait - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_en            = w_rd;
  assign rd_addr          = w_rd ? w_addr : '0;
  assign pixel_out        = r_pixel;
  assign valid_out        = r_valid;
  assign color_out        = r_color;
  assign last_col_out     = r_last_col;
  assign last_pic_out     = r_last_pic;
  assign finish_operation = r_finish;
  assign busy             = (r_state != S_IDLE) || r_finish;
  assign cfg_err          = r_cfg_err;

endmodule

// File: tb/tb_bayer_tx.sv
// Directed bench for bayer_tx: frame buffer returns the low address byte as data.
`timescale 1ns/1ps
module tb_bayer_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  size_w_log2 = 4'd0, size_h_log2 = 4'd0, line_gap = 4'd0;
  logic [1:0]  pattern = 2'd0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  pixel_out;
  logic        valid_out;
  logic [1:0]  color_out;
  logic        last_col_out, last_pic_out, busy, finish_operation, cfg_err;

  bayer_tx dut (
    .clk(clk), .rst(rst), .start(start),
    .size_w_log2(size_w_log2), .size_h_log2(size_h_log2),
    .pattern(pattern), .line_gap(line_gap),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixel_out(pixel_out), .valid_out(valid_out), .color_out(color_out),
    .last_col_out(last_col_out), .last_pic_out(last_pic_out),
    .busy(busy), .finish_operation(finish_operation), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rd_en ? rd_addr[7:0] : 8'd0;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {31'd0, rd_en, rd_addr, pixel_out, valid_out, color_out,
            last_col_out, last_pic_out, busy, finish_operation, cfg_err};
  endfunction

  // Results of the most recent frame
  int fr_fin_rel, fr_nvalid, fr_nlastpic, fr_data_err, fr_idle_err;
  int fr_ncfg, fr_busy_err, fr_nrd, fr_busy_after;
  int fr_last_addr;
  int fr_color[16], fr_lc[16], fr_lp[16], fr_rel[16];

  // rel=1 is the first sample after the accepting edge.
  task automatic run_frame(input logic [3:0] wl, input logic [3:0] hl, input logic [1:0] pat,
                           input logic [3:0] gap, input int restart_rel, input int budget);
    int rel;
    fr_fin_rel = -1; fr_nvalid = 0; fr_nlastpic = 0; fr_data_err = 0; fr_idle_err = 0;
    fr_ncfg = 0; fr_busy_err = 0; fr_nrd = 0; fr_last_addr = 0;
    size_w_log2 = wl; size_h_log2 = hl; pattern = pat; line_gap = gap;
    start = 1'b1;
    tick();
    start = 1'b0;
    rel = 1;
    forever begin
      start = (rel == restart_rel);
      if (rel == restart_rel) begin
        size_w_log2 = 4'd1; size_h_log2 = 4'd3; pattern = 2'd3; line_gap = 4'd5;
      end
      if (!busy) fr_busy_err++;
      if (cfg_err) fr_ncfg++;
      if (rd_en) begin
        fr_nrd++;
        fr_last_addr = int'(rd_addr);
      end
      if (valid_out) begin
        if (fr_nvalid < 16) begin
          fr_color[fr_nvalid] = int'(color_out);
          fr_lc[fr_nvalid]    = int'(last_col_out);
          fr_lp[fr_nvalid]    = int'(last_pic_out);
          fr_rel[fr_nvalid]   = rel;
        end
        if (pixel_out != fr_nvalid[7:0]) fr_data_err++;
        if (last_pic_out) fr_nlastpic++;
        fr_nvalid++;
      end else if (pixel_out != 8'd0 || color_out != 2'd0 || last_col_out || last_pic_out) begin
        fr_idle_err++;
      end
      if (finish_operation) begin
        fr_fin_rel = rel;
        break;
      end
      if (rel >= budget) begin
        check("frame_timeout", finish_operation, 1);
        break;
      end
      tick();
      rel++;
    end
    start = 1'b0;
    tick();
    fr_busy_after = int'(busy);
  endtask

  task automatic check_basic(input string tag, input int gap);
    int exp_col[8] = '{0, 1, 0, 1, 1, 2, 1, 2};
    check({tag, "_nvalid"}, fr_nvalid, 8);
    check({tag, "_data"}, fr_data_err, 0);
    check({tag, "_idle_zero"}, fr_idle_err, 0);
    check({tag, "_busy"}, fr_busy_err, 0);
    check({tag, "_busy_after"}, fr_busy_after, 0);
    check({tag, "_cfg_err"}, fr_ncfg, 0);
    check({tag, "_nrd"}, fr_nrd, 8);
    check({tag, "_last_addr"}, fr_last_addr, 7);
    check({tag, "_nlastpic"}, fr_nlastpic, 1);
    check({tag, "_finish_rel"}, fr_fin_rel, 11 + gap);
    check({tag, "_gap_spacing"}, fr_rel[4] - fr_rel[3], 1 + gap);
    check({tag, "_tail"}, fr_fin_rel - fr_rel[7], 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_color%0d", tag, k), fr_color[k], exp_col[k]);
      check($sformatf("%s_lastcol%0d", tag, k), fr_lc[k], (k == 3 || k == 7) ? 1 : 0);
      check($sformatf("%s_lastpic%0d", tag, k), fr_lp[k], (k == 7) ? 1 : 0);
    end
  endtask

  task automatic check_2x2(input string tag, input logic [1:0] pat, input int c0, input int c1,
                           input int c2, input int c3);
    run_frame(4'd1, 4'd1, pat, 4'd0, -1, 50);
    check({tag, "_nvalid"}, fr_nvalid, 4);
    check({tag, "_c0"}, fr_color[0], c0);
    check({tag, "_c1"}, fr_color[1], c1);
    check({tag, "_c2"}, fr_color[2], c2);
    check({tag, "_c3"}, fr_color[3], c3);
    check({tag, "_finish_rel"}, fr_fin_rel, 7);
    $display("frame %s: pixels=%0d finish_rel=%0d", tag, fr_nvalid, fr_fin_rel);
  endtask

  task automatic bad_cfg(input string tag, input logic [3:0] wl, input logic [3:0] hl);
    size_w_log2 = wl; size_h_log2 = hl; pattern = 2'd0; line_gap = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_cfg_err"}, cfg_err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    tick();
    check({tag, "_cfg_err_pulse"}, cfg_err, 0);
    check({tag, "_busy2"}, busy, 0);
    check({tag, "_rd_en2"}, rd_en, 0);
    $display("bad config %s: w_log2=%0d h_log2=%0d", tag, wl, hl);
  endtask

  initial begin
    int nv;
    int nact;

    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    tick();

    run_frame(4'd2, 4'd1, 2'd0, 4'd0, -1, 100);
    check_basic("basic", 0);
    $display("frame basic: pixels=%0d finish_rel=%0d", fr_nvalid, fr_fin_rel);

    run_frame(4'd2, 4'd1, 2'd0, 4'd3, -1, 100);
    check_basic("gap3", 3);
    $display("frame gap3: pixels=%0d finish_rel=%0d", fr_nvalid, fr_fin_rel);

    check_2x2("bggr", 2'd3, 2, 1, 1, 0);
    check_2x2("grbg", 2'd1, 1, 0, 2, 1);

    bad_cfg("w0", 4'd0, 4'd1);
    bad_cfg("w9", 4'd9, 4'd1);
    bad_cfg("h0", 4'd2, 4'd0);

    // A second start (with new settings) mid-frame must change nothing.
    run_frame(4'd2, 4'd1, 2'd0, 4'd0, 3, 100);
    check_basic("restart", 0);
    $display("frame restart: pixels=%0d finish_rel=%0d", fr_nvalid, fr_fin_rel);

    // Reset after the 5th pixel of a 16x16 frame, with start raised at the same time.
    size_w_log2 = 4'd4; size_h_log2 = 4'd4; pattern = 2'd0; line_gap = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 100 && nv < 5; i++) begin
      if (valid_out) nv++;
      if (nv < 5) tick();
    end
    check("rst_pre_pixels", nv, 5);
    rst = 1'b1;
    start = 1'b1;
    tick();
    check("rst_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    nact = 0;
    repeat (20) begin
      tick();
      if (finish_operation || valid_out || busy || rd_en) nact++;
    end
    check("rst_quiet", nact, 0);
    $display("mid-frame reset: pixels_before=%0d activity_after=%0d", nv, nact);

    run_frame(4'd2, 4'd1, 2'd0, 4'd0, -1, 100);
    check_basic("after_rst", 0);
    $display("frame after_rst: pixels=%0d finish_rel=%0d", fr_nvalid, fr_fin_rel);

    run_frame(4'd8, 4'd8, 2'd0, 4'd0, -1, 70000);
    check("max_nvalid", fr_nvalid, 65536);
    check("max_last_addr", fr_last_addr, 16'hFFFF);
    check("max_nlastpic", fr_nlastpic, 1);
    check("max_data", fr_data_err, 0);
    check("max_idle_zero", fr_idle_err, 0);
    check("max_finish_rel", fr_fin_rel, 65539);
    $display("frame max: pixels=%0d last_addr=%0h finish_rel=%0d", fr_nvalid, fr_last_addr, fr_fin_rel);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
